// File: rtl/adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit slice adder: {c4, sum} = a + b + cin.
module nibble_add4
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c4
);

  // Widen by one bit so the carry falls out of the top.
  always_comb begin
    {c4, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two W-bit operands one 4-bit slice per cycle,
// LSB nibble first, with the slice carry held in a flop between cycles.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in_b,
  input  logic                         in_cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  out_sum,
  output logic                         out_cout
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        sum_reg;
  logic                cout_reg;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                c4;
  logic                accept;
  logic                last_nib;

  // Handshake flags come straight off the state register; masked while in reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign accept    = in_valid && in_ready;
  assign last_nib  = (idx == IDX_W'(NIBBLES - 1));

  // Select the current operand slice using constant part-selects.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Single shared slice adder.
  nibble_add4 u_add4 (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry),
    .sum (s_nib),
    .c4  (c4)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last_nib) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, per-nibble accumulate, carry chain, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
          end
          carry <= c4;
          if (last_nib) begin
            cout_reg <= c4;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
